// File: rtl/alu_seq.sv
// Execute-stage ALU with valid/ready on both sides. Single-cycle logic/arithmetic ops;
// SLL/SRL/SRA run on an iterative 1-bit-per-cycle shifter. Result held until consumed.
module alu_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] aluop,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              busy
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [AWIDTH-1:0] ALU_ADD      = AWIDTH'(0);
    localparam logic [AWIDTH-1:0] ALU_SUB      = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] ALU_XOR      = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] ALU_OR       = AWIDTH'(3);
    localparam logic [AWIDTH-1:0] ALU_AND      = AWIDTH'(4);
    localparam logic [AWIDTH-1:0] ALU_SLT      = AWIDTH'(5);
    localparam logic [AWIDTH-1:0] ALU_SLTU     = AWIDTH'(6);
    localparam logic [AWIDTH-1:0] ALU_SLL      = AWIDTH'(7);
    localparam logic [AWIDTH-1:0] ALU_SRL      = AWIDTH'(8);
    localparam logic [AWIDTH-1:0] ALU_SRA      = AWIDTH'(9);
    localparam logic [AWIDTH-1:0] ALU_SHIFT    = AWIDTH'(10);
    localparam logic [AWIDTH-1:0] ALU_SHIFTADD = AWIDTH'(11);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [SW-1:0]     count;
    logic [AWIDTH-1:0] op_q;
    logic [WIDTH-1:0]  alu_c;
    logic [WIDTH-1:0]  shift_c;
    logic [SW-1:0]     shamt;
    logic              is_shift;
    logic              accept;

    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign shamt    = op_b[SW-1:0];
    assign is_shift = (aluop == ALU_SLL) | (aluop == ALU_SRL) | (aluop == ALU_SRA);

    // Single-cycle datapath; shift ops here only cover the shamt=0 pass-through
    always_comb begin
        alu_c = op_a + op_b;
        case (aluop)
            ALU_SUB:      alu_c = op_a - op_b;
            ALU_XOR:      alu_c = op_a ^ op_b;
            ALU_OR:       alu_c = op_a | op_b;
            ALU_AND:      alu_c = op_a & op_b;
            ALU_SLT:      alu_c = WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU:     alu_c = WIDTH'(op_a < op_b);
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:      alu_c = op_a;
            ALU_SHIFT:    alu_c = op_b << 12;
            ALU_SHIFTADD: alu_c = op_a + (op_b << 12);
            default:      alu_c = op_a + op_b;
        endcase
    end

    // One bit of the iterative shift; result doubles as the shift accumulator
    always_comb begin
        shift_c = {result[WIDTH-1], result[WIDTH-1:1]};
        case (op_q)
            ALU_SLL: shift_c = {result[WIDTH-2:0], 1'b0};
            ALU_SRL: shift_c = {1'b0, result[WIDTH-1:1]};
            default: shift_c = {result[WIDTH-1], result[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            op_q      <= ALU_ADD;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_shift && (shamt != '0)) begin
                            state     <= S_SHIFT;
                            result    <= op_a;
                            zero      <= 1'b0;
                            count     <= shamt;
                            op_q      <= aluop;
                            out_valid <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            state     <= S_DONE;
                            result    <= alu_c;
                            zero      <= (alu_c == '0);
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    result <= shift_c;
                    count  <= count - SW'(1);
                    if (count == SW'(1)) begin
                        state     <= S_DONE;
                        zero      <= (shift_c == '0);
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results queued on accept, checked on output handshake,
// plus latency, busy, stall, and mid-shift reset checks.
module tb_alu_seq;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR_ = 4'd2, OR_ = 4'd3, AND_ = 4'd4,
                           SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9,
                           SHIFT = 4'd10, SHIFTADD = 4'd11;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [3:0]  aluop;
    logic [31:0] op_a, op_b;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        zero, busy;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_seq #(.WIDTH(32), .AWIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            SUB:      return a - b;
            XOR_:     return a ^ b;
            OR_:      return a | b;
            AND_:     return a & b;
            SLT:      return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:     return (a < b) ? 32'd1 : 32'd0;
            SLL:      return a << sh;
            SRL:      return a >> sh;
            SRA:      return 32'($signed(a) >>> sh);
            SHIFT:    return b << 12;
            SHIFTADD: return a + (b << 12);
            default:  return a + b;
        endcase
    endfunction

    // Output side of the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_unexpected_output", 32'(q.size()), 32'd1);
            end else begin
                mon_e = q.pop_front();
                check("result", result, mon_e.r);
                check("zero", 32'(zero), 32'(mon_e.z));
            end
        end
    end

    // Issue one op, queue its expected value, and check latency and busy cycles.
    // Entered and left at posedge+1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sh, exp_lat, exp_busy, lat, busy_n;
        bit   ok, shift_op;
        e.r      = model(op, a, b);
        e.z      = (e.r == 32'd0);
        sh       = int'(b[4:0]);
        shift_op = (op == SLL) || (op == SRL) || (op == SRA);
        exp_lat  = (shift_op && sh != 0) ? sh + 1 : 1;
        exp_busy = shift_op ? sh : 0;
        aluop    = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aluop    = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat      = 0;
        busy_n   = 0;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("out_valid_seen", 32'(ok), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_n), 32'(exp_busy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        aluop     = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(ADD, 32'h7FFF_FFFF, 32'd1);
        run_op(SUB, 32'd5, 32'd5);
        run_op(SRA, 32'h8000_0000, 32'd4);
        run_op(SLL, 32'h1234_5678, 32'h20);
        run_op(SLT, 32'hFFFF_FFFF, 32'd1);
        run_op(SLTU, 32'hFFFF_FFFF, 32'd1);
        run_op(SHIFTADD, 32'h1000, 32'd1);
        run_op(SHIFT, 32'h0, 32'hABCDE);
        run_op(4'hF, 32'd3, 32'd4);
        run_op(SRL, 32'hDEAD_BEEF, 32'd31);
        run_op(XOR_, 32'hF0F0_F0F0, 32'hF0F0_F0F0);

        // Stall: result must hold while the consumer is not ready
        out_ready = 1'b0;
        run_op(ADD, 32'h7FFF_FFFF, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_result", result, 32'h8000_0000);
            check("stall_zero", 32'(zero), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        run_op(OR_, 32'h00FF_0000, 32'h0000_00FF);

        // Reset mid-shift, with a competing op held on the input during the shift
        aluop    = SRL;
        op_a     = 32'hFFFF_0000;
        op_b     = 32'd20;
        in_valid = 1'b1;
        @(negedge clk);
        check("srl_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        aluop = ADD;
        op_a  = 32'd1;
        op_b  = 32'd1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("shift_in_ready", 32'(in_ready), 32'd0);
            check("shift_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);

        // Random ops against the model
        for (int i = 0; i < 30; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
